mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  Multiply/divide unit controller for the E stage of the 5-stage MIPS pipeline.
//  Latches operands on a start pulse and times the fixed-latency mult/div operation.
//  Owns HI/LO and drives the busy flag consumed by hazard control for mfhi/mflo stalls.
//  Handles mthi/mtlo writes directly.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//  DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//  clk      in   1   system clock, all state on rising edge
//  reset    in   1   asynchronous, active-high; clears all state
//  start    in   1   launch mult/multu/div/divu selected by op (E stage)
//  op       in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo, others none
//  A        in   32  operand rs (forwarded value)
//  B        in   32  operand rt (forwarded value)
//  busy     out  1   operation in progress
//  HI       out  32  HI register
//  LO       out  32  LO register
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, cnt=0, busy=0, HI=0, LO=0, operand regs=0.
//  FSM states: IDLE, MUL, DIV.
//  IDLE: start=1 with op 1/2 -> latch A,B,op; cnt=MULT_CYCLES; state=MUL.
//  IDLE: start=1 with op 3/4 -> same latch; cnt=DIV_CYCLES; state=DIV.
//  IDLE: start=1 with op 0/5/6/other -> ignored, no state change.
//  IDLE: start=0, op=5 -> HI<=A at this edge; op=6 -> LO<=A; busy stays 0.
//  MUL/DIV: busy=1; cnt decrements each edge.
//  MUL/DIV at the edge where cnt==1: HI/LO commit, state=IDLE, busy=0.
//  Timing: start high in cycle T -> busy high T+1..T+N (N = MULT_CYCLES or DIV_CYCLES).
//  Timing: new HI/LO visible from cycle T+N+1.
//  busy is a registered output, purely (state!=IDLE); hazard control stalls on start|busy.
//  mult: {HI,LO} = $signed(A)*$signed(B), 64-bit. multu: unsigned 64-bit product.
//  div: LO = signed quotient truncated toward zero; HI = remainder, sign of dividend.
//  divu: unsigned quotient/remainder.
//  Divide by zero (latched B==0): HI/LO unchanged at commit; latency still DIV_CYCLES.
//  Signed 0x80000000 / -1: LO=0x80000000, HI=0 (wraps, no trap).
//  Result is computed from latched operands only.
//  A/B/op changes while busy have no effect on the result.
//  start or op 5/6 while busy: ignored, no restart, HI/LO untouched (hazard control never issues these).
//  HI/LO read combinationally from registers; values during busy = previous values.
//  Reset mid-operation: operation abandoned, HI/LO=0, busy=0 asynchronously.
// TESTING
//  reset; start, op=1, A=-3, B=7 -> busy 1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFEB, busy=0.
//  start, op=2, A=0xFFFFFFFF, B=2 -> after 5 busy cycles HI=1, LO=0xFFFFFFFE.
//  start, op=3, A=-7, B=2 -> busy 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  Second start, op=4, issued during busy -> still exactly 10 busy cycles; result from first operands.
//  HI=5; start, op=4, B=0 -> 10 busy cycles; HI/LO unchanged (HI still 5).
//  op=5, A=0x1234 (idle) -> next cycle HI=0x1234, busy never rises.
//  Assert reset at cycle 3 of a DIV -> busy=0, HI=LO=0 immediately.
//  After that reset, a new start behaves normally.

Source files
------------

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide controller for the E stage.
// Latches operands on a start pulse, times a fixed-latency mult/div, owns
// HI/LO and reports busy for mfhi/mflo hazard stalls. Also handles mthi/mtlo.
// Ports:
//   clk, reset    clock (rising edge), asynchronous active-high reset
//   start         launch the mult/div selected by op
//   op[3:0]       0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   A, B [31:0]   forwarded rs/rt operands
//   busy          registered, high while an operation is in flight
//   HI, LO [31:0] architectural HI/LO registers
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        hi_q, hi_d, lo_q, lo_d;
  logic               busy_q, busy_d;

  logic [63:0]        prod;
  logic [31:0]        quo, rem;
  logic [31:0]        abs_a, abs_b, uq, ur;

  // Arithmetic on latched operands only; the commit picks the result.
  always_comb begin
    if (op_q == OP_MULT) begin
      // Low 64 bits of the sign-extended product equal the signed product.
      prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    end else begin
      prod = {32'd0, a_q} * {32'd0, b_q};
    end

    // Signed divide via magnitudes; min/-1 falls out as 0x80000000 rem 0.
    abs_a = a_q;
    abs_b = b_q;
    if (op_q == OP_DIV) begin
      abs_a = a_q[31] ? (32'd0 - a_q) : a_q;
      abs_b = b_q[31] ? (32'd0 - b_q) : b_q;
    end
    uq  = (abs_b != 32'd0) ? (abs_a / abs_b) : 32'd0;
    ur  = (abs_b != 32'd0) ? (abs_a % abs_b) : 32'd0;
    quo = uq;
    rem = ur;
    if (op_q == OP_DIV) begin
      quo = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
      rem = a_q[31] ? (32'd0 - ur) : ur;
    end
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MULT || op == OP_MULTU) begin
            a_d     = A;
            b_d     = B;
            op_d    = op;
            cnt_d   = CNT_W'(MULT_CYCLES);
            state_d = MUL;
          end else if (op == OP_DIV || op == OP_DIVU) begin
            a_d     = A;
            b_d     = B;
            op_d    = op;
            cnt_d   = CNT_W'(DIV_CYCLES);
            state_d = DIV;
          end
        end else if (op == OP_MTHI) begin
          hi_d = A;
        end else if (op == OP_MTLO) begin
          lo_d = A;
        end
      end
      MUL: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = prod[63:32];
          lo_d    = prod[31:0];
          state_d = IDLE;
        end
      end
      DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Divide by zero leaves HI/LO untouched.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quo;
          end
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed self-checking bench for mdu_ctrl.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests;
  int fails;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle, then count busy cycles (bounded).
  task automatic launch(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 4'd0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      fails++;
      $display("FAIL reset: busy=%b HI=%h LO=%h, want 0/0/0", busy, HI, LO);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult();
    int n;
    launch(4'd1, 32'hFFFFFFFD, 32'd7, n);
    tests++;
    if (n !== 5) begin
      fails++; $display("FAIL mult_busy: got %0d cycles, want 5", n);
    end
    tests++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
      fails++; $display("FAIL mult_result: HI=%h LO=%h, want ffffffff/ffffffeb", HI, LO);
    end
  endtask

  task automatic test_multu();
    int n;
    launch(4'd2, 32'hFFFFFFFF, 32'd2, n);
    tests++;
    if (n !== 5) begin
      fails++; $display("FAIL multu_busy: got %0d cycles, want 5", n);
    end
    tests++;
    if (HI !== 32'd1 || LO !== 32'hFFFFFFFE) begin
      fails++; $display("FAIL multu_result: HI=%h LO=%h, want 00000001/fffffffe", HI, LO);
    end
  endtask

  // Signed div with a second start and operand churn while busy.
  task automatic test_back_to_back();
    int n;
    @(negedge clk);
    start = 1'b1; op = 4'd3; A = 32'hFFFFFFF9; B = 32'd2;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    tests++;
    if (busy !== 1'b1 || HI !== 32'd1 || LO !== 32'hFFFFFFFE) begin
      fails++;
      $display("FAIL div_hold: busy=%b HI=%h LO=%h, want 1/00000001/fffffffe", busy, HI, LO);
    end
    n = 1;
    @(negedge clk);
    start = 1'b1; op = 4'd4; A = 32'd100; B = 32'd3;
    if (busy === 1'b1) n++;
    @(negedge clk);
    start = 1'b0; op = 4'd5; A = 32'h55; B = 32'd0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    op = 4'd0;
    tests++;
    if (n !== 10) begin
      fails++; $display("FAIL div_busy: got %0d cycles, want 10", n);
    end
    tests++;
    if (HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFFD) begin
      fails++; $display("FAIL div_result: HI=%h LO=%h, want ffffffff/fffffffd", HI, LO);
    end
  endtask

  task automatic test_mthi_mtlo();
    @(negedge clk);
    op = 4'd5; A = 32'h1234;
    @(negedge clk);
    op = 4'd0;
    tests++;
    if (HI !== 32'h1234 || busy !== 1'b0 || LO !== 32'hFFFFFFFD) begin
      fails++; $display("FAIL mthi: HI=%h busy=%b LO=%h, want 00001234/0/fffffffd", HI, busy, LO);
    end
    op = 4'd6; A = 32'hABCD;
    @(negedge clk);
    op = 4'd0;
    tests++;
    if (LO !== 32'hABCD || busy !== 1'b0 || HI !== 32'h1234) begin
      fails++; $display("FAIL mtlo: LO=%h busy=%b HI=%h, want 0000abcd/0/00001234", LO, busy, HI);
    end
    // start together with mthi is ignored
    start = 1'b1; op = 4'd5; A = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    tests++;
    if (HI !== 32'h1234 || busy !== 1'b0) begin
      fails++; $display("FAIL start_mthi_ignored: HI=%h busy=%b, want 00001234/0", HI, busy);
    end
  endtask

  task automatic test_div_zero();
    int n;
    @(negedge clk);
    op = 4'd5; A = 32'd5;
    @(negedge clk);
    op = 4'd0;
    launch(4'd4, 32'd77, 32'd0, n);
    tests++;
    if (n !== 10) begin
      fails++; $display("FAIL divzero_busy: got %0d cycles, want 10", n);
    end
    tests++;
    if (HI !== 32'd5 || LO !== 32'hABCD) begin
      fails++; $display("FAIL divzero_result: HI=%h LO=%h, want 00000005/0000abcd", HI, LO);
    end
  endtask

  task automatic test_div_overflow();
    int n;
    launch(4'd3, 32'h80000000, 32'hFFFFFFFF, n);
    tests++;
    if (n !== 10 || HI !== 32'd0 || LO !== 32'h80000000) begin
      fails++;
      $display("FAIL div_overflow: n=%0d HI=%h LO=%h, want 10/00000000/80000000", n, HI, LO);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    @(negedge clk);
    start = 1'b1; op = 4'd4; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (2) @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL midop_busy: busy=%b, want 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
      fails++;
      $display("FAIL midop_reset: busy=%b HI=%h LO=%h, want 0/0/0", busy, HI, LO);
    end
    @(negedge clk);
    reset = 1'b0;
    launch(4'd2, 32'd6, 32'd7, n);
    tests++;
    if (n !== 5 || HI !== 32'd0 || LO !== 32'd42) begin
      fails++; $display("FAIL post_reset_multu: n=%0d HI=%h LO=%h, want 5/0/42", n, HI, LO);
    end
    launch(4'd4, 32'd100, 32'd7, n);
    tests++;
    if (n !== 10 || HI !== 32'd2 || LO !== 32'd14) begin
      fails++; $display("FAIL post_reset_divu: n=%0d HI=%h LO=%h, want 10/2/14", n, HI, LO);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_mult();
    test_multu();
    test_back_to_back();
    test_mthi_mtlo();
    test_div_zero();
    test_div_overflow();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
